// File: rtl/muldiv_alu_seq.sv
// Registered ALU with iterative unsigned multiply/divide and a valid/ready handshake.
// Optional signed ADD/SUB overflow flag is enabled by defining ALU_OVF_EN.
module muldiv_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    input  logic [2:0]       alu_ctr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_result_hi,
    output logic             zero_bit,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpMulu = 3'b010;
    localparam logic [2:0] OpDivu = 3'b011;
    localparam logic [2:0] OpSlt  = 3'b100;
    localparam logic [2:0] OpAdd  = 3'b101;
    localparam logic [2:0] OpSub  = 3'b110;
    localparam logic [2:0] OpNor  = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    // Shared working registers: acc_hi is the product high half or the partial remainder,
    // acc_lo the multiplier or the dividend/quotient shift register, opnd the other operand.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] simple_res;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx;
    logic [WIDTH-1:0] div_quo_nx;

    assign in_ready = (state == StIdle);

    assign add_res = alu_src1 + alu_src2;
    assign sub_res = alu_src1 - alu_src2;

    always_comb begin
        simple_res = '0;
        case (alu_ctr)
            OpAnd:   simple_res = alu_src1 & alu_src2;
            OpOr:    simple_res = alu_src1 | alu_src2;
            OpSlt:   simple_res = {{(WIDTH-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
            OpAdd:   simple_res = add_res;
            OpSub:   simple_res = sub_res;
            OpNor:   simple_res = ~(alu_src1 | alu_src2);
            default: simple_res = '0;
        endcase
    end

    // Shift-add step: add the multiplicand when the current multiplier bit is set, shift right.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, subtract when the divisor fits.
    assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge     = (div_shift >= {1'b0, opnd});
    assign div_rem_nx = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
    assign div_quo_nx = {acc_lo[WIDTH-2:0], div_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            count         <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            opnd          <= '0;
            out_valid     <= 1'b0;
            alu_result    <= '0;
            alu_result_hi <= '0;
            zero_bit      <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        case (alu_ctr)
                            OpMulu: begin
                                acc_hi <= '0;
                                acc_lo <= alu_src2;
                                opnd   <= alu_src1;
                                count  <= CNT_W'(WIDTH);
                                state  <= StMul;
                            end
                            OpDivu: begin
                                if (alu_src2 == '0) begin
                                    alu_result    <= '1;
                                    alu_result_hi <= alu_src1;
                                    zero_bit      <= 1'b0;
                                    div_by_zero   <= 1'b1;
                                    out_valid     <= 1'b1;
                                    state         <= StDone;
                                end else begin
                                    acc_hi <= '0;
                                    acc_lo <= alu_src1;
                                    opnd   <= alu_src2;
                                    count  <= CNT_W'(WIDTH);
                                    state  <= StDiv;
                                end
                            end
                            default: begin
                                alu_result    <= simple_res;
                                alu_result_hi <= '0;
                                zero_bit      <= (simple_res == '0);
                                div_by_zero   <= 1'b0;
                                out_valid     <= 1'b1;
                                state         <= StDone;
                            end
                        endcase
                    end
                end
                StMul: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    count  <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        alu_result    <= mul_lo_nx;
                        alu_result_hi <= mul_hi_nx;
                        zero_bit      <= (mul_lo_nx == '0);
                        out_valid     <= 1'b1;
                        state         <= StDone;
                    end
                end
                StDiv: begin
                    acc_hi <= div_rem_nx;
                    acc_lo <= div_quo_nx;
                    count  <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        alu_result    <= div_quo_nx;
                        alu_result_hi <= div_rem_nx;
                        zero_bit      <= (div_quo_nx == '0);
                        out_valid     <= 1'b1;
                        state         <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        zero_bit    <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef ALU_OVF_EN
    logic ovf_calc;

    always_comb begin
        ovf_calc = 1'b0;
        if (alu_ctr == OpAdd) begin
            ovf_calc = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) &&
                       (add_res[WIDTH-1] != alu_src1[WIDTH-1]);
        end else if (alu_ctr == OpSub) begin
            ovf_calc = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) &&
                       (sub_res[WIDTH-1] != alu_src1[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (state == StIdle && in_valid) begin
            overflow <= ovf_calc;
        end else if (state == StDone && out_ready) begin
            overflow <= 1'b0;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
